// File: rtl/soft_tbm_mc.sv
// soft_tbm_mc: multi-chain soft TBM emulator.
// Decodes trigger-bus events and drives ROC/TBM command strobes. Triggers are
// queued and then read out one at a time: two header words, a serial token
// pass through every enabled chain, and three trailer words.
// Every state change is qualified by the sync clock-enable.
// Optional build macro SOFT_TBM_MC_TOUT_DELAY_EN adds a 16-tick tout delay
// line per chain, selected at run time by tout_delay_ena.
module soft_tbm_mc #(
  parameter int NCH       = 4,
  parameter int QDEPTH    = 16,
  parameter int RO_DELAY  = 10,
  parameter int TRL_DELAY = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sync,
  input  logic [4:0]       trg_in,
  input  logic [3:0]       trg_pos,
  input  logic [NCH-1:0]   chain_ena,
  input  logic [15:0]      token_timeout,
  output logic [NCH-1:0]   tin,
  input  logic [NCH-1:0]   tout,
`ifdef SOFT_TBM_MC_TOUT_DELAY_EN
  input  logic             tout_delay_ena,
`endif
  output logic [NCH-1:0]   deser_ena,
  output logic             cmd_trg,
  output logic             cmd_rsr,
  output logic             cmd_rst,
  output logic             cmd_cal,
  output logic             daq_write,
  output logic [15:0]      daq_data,
  output logic [4:0]       queue_size
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  // Flag bit positions inside the per-trigger flag field
  localparam int F_STKF = 0;
  localparam int F_REST = 1;
  localparam int F_RESR = 2;
  localparam int F_SYNC = 3;
  localparam int F_CAL  = 4;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR1, S_HDR2, S_TIN, S_WAIT, S_NEXT, S_TRLW, S_TRL1, S_TRL2, S_TRL3
  } state_t;

  state_t            state, state_nxt;

  logic              ev_syn, ev_trg, ev_rsr, ev_rst, ev_cal;
  logic              q_full, q_empty, push, pop, ro_enable;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [7:0]        q_ev  [QDEPTH];
  logic [3:0]        q_pos [QDEPTH];
  logic [4:0]        q_flg [QDEPTH];
  logic [QDEPTH-1:0] q_tok;
  logic [7:0]        h_ev;
  logic [3:0]        h_pos;
  logic [4:0]        h_flg;
  logic              h_tok;

  logic [7:0]        ev_cnt;
  logic [4:0]        flags, flg_set, flg_merged;
  logic [15:0]       ro_veto;

  logic [CW-1:0]     ch;
  logic [NCH-1:0]    chain_mask, to_mask, tout_eff;
  logic [15:0]       timer, trl_cnt;
  logic              ntok, tout_ch, tmo_hit, word_vld;
  logic [CW:0]       first_pick, nxt_pick;
  logic [7:0]        to_mask8;

  // Lowest enabled chain at or above start; MSB of the result is 'found'.
  function automatic logic [CW:0] pick_chain(input logic [NCH-1:0] mask, input int start);
    logic [CW:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= start)) r = {1'b1, CW'(i)};
    end
    return r;
  endfunction

  // Event decode: the bus is only meaningful on sync ticks
  assign ev_syn = sync & trg_in[0];
  assign ev_trg = sync & trg_in[1];
  assign ev_rsr = sync & trg_in[2];
  assign ev_rst = sync & trg_in[3];
  assign ev_cal = sync & trg_in[4];

  assign q_full    = (queue_size == 5'(QDEPTH));
  assign q_empty   = (queue_size == 5'd0);
  assign push      = ev_trg & ~q_full & ~ev_rst;
  assign pop       = sync & (state == S_TRL2) & ~ev_rst;
  assign ro_enable = ~q_empty & (ro_veto == 16'd0);

  assign h_ev  = q_ev[rd_ptr];
  assign h_pos = q_pos[rd_ptr];
  assign h_flg = q_flg[rd_ptr];
  assign h_tok = q_tok[rd_ptr];

  // Flags raised this tick are attributed to a trigger pushed in the same tick
  assign flg_set[F_STKF] = ev_trg & q_full & ~ev_rst;
  assign flg_set[F_REST] = ev_rst;
  assign flg_set[F_RESR] = ev_rsr | ev_rst;
  assign flg_set[F_SYNC] = ev_syn;
  assign flg_set[F_CAL]  = ev_cal;
  assign flg_merged      = flags | flg_set;

`ifdef SOFT_TBM_MC_TOUT_DELAY_EN
  logic [15:0]    tout_sr [NCH];
  logic [NCH-1:0] tout_dly;

  // Per-chain tout delay line, advanced on sync ticks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) tout_sr[i] <= '0;
    end else if (sync) begin
      for (int i = 0; i < NCH; i++) tout_sr[i] <= {tout_sr[i][14:0], tout[i]};
    end
  end

  // Tap the last stage of each delay line
  always_comb begin
    tout_dly = '0;
    for (int i = 0; i < NCH; i++) tout_dly[i] = tout_sr[i][15];
  end

  assign tout_eff = tout_delay_ena ? tout_dly : tout;
`else
  assign tout_eff = tout;
`endif

  assign tout_ch    = tout_eff[ch];
  assign tmo_hit    = sync & (state == S_WAIT) & ~tout_ch & ~flags[F_RESR] & (timer <= 16'd1);
  assign first_pick = pick_chain(chain_ena, 0);
  assign nxt_pick   = pick_chain(chain_mask, int'(ch) + 1);
  assign to_mask8   = 8'(to_mask);

  // Queue payload storage; contents are only meaningful while occupied
  always_ff @(posedge clk) begin
    if (push) begin
      q_ev[wr_ptr]  <= ev_cnt;
      q_pos[wr_ptr] <= trg_pos;
      q_flg[wr_ptr] <= flg_merged;
    end
  end

  // Queue control: token bits, pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_tok      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      queue_size <= '0;
    end else if (ev_rst) begin
      q_tok      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      queue_size <= '0;
    end else begin
      if (ev_rsr) q_tok <= '0;
      if (push) begin
        q_tok[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   queue_size <= queue_size + 5'd1;
        2'b01:   queue_size <= queue_size - 5'd1;
        default: queue_size <= queue_size;
      endcase
    end
  end

  // Event counter, status flags and readout veto
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ev_cnt  <= '0;
      flags   <= '0;
      ro_veto <= '0;
    end else if (sync) begin
      if (ev_syn)    ev_cnt <= '0;
      else if (push) ev_cnt <= ev_cnt + 8'd1;
      flags <= push ? 5'd0 : flg_merged;
      if (push && (queue_size <= 5'd1)) ro_veto <= 16'(RO_DELAY);
      else if (ro_veto != 16'd0)        ro_veto <= ro_veto - 16'd1;
    end
  end

  // Command strobes, each held for exactly one sync tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_trg <= 1'b0;
      cmd_rsr <= 1'b0;
      cmd_rst <= 1'b0;
      cmd_cal <= 1'b0;
    end else if (sync) begin
      cmd_trg <= push;
      cmd_rsr <= ev_rsr | ev_rst | tmo_hit;
      cmd_rst <= ev_rst;
      cmd_cal <= ev_cal;
    end
  end

  // Readout state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Readout next-state logic
  always_comb begin
    state_nxt = state;
    if (sync) begin
      if (ev_rst) begin
        state_nxt = S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (ro_enable) state_nxt = S_HDR1;
          S_HDR1: state_nxt = S_HDR2;
          S_HDR2: state_nxt = (h_tok && (chain_ena != '0)) ? S_TIN : S_TRL1;
          S_TIN:  state_nxt = S_WAIT;
          S_WAIT: if (tout_ch || flags[F_RESR] || (timer <= 16'd1)) state_nxt = S_NEXT;
          S_NEXT: state_nxt = nxt_pick[CW] ? S_TIN : S_TRLW;
          S_TRLW: if (trl_cnt <= 16'd1) state_nxt = S_TRL1;
          S_TRL1: state_nxt = S_TRL2;
          S_TRL2: state_nxt = S_TRL3;
          S_TRL3: state_nxt = S_IDLE;
          default: state_nxt = S_IDLE;
        endcase
      end
    end
  end

  // Token-pass bookkeeping: current chain, timers, masks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch         <= '0;
      chain_mask <= '0;
      to_mask    <= '0;
      timer      <= '0;
      trl_cnt    <= '0;
      ntok       <= 1'b0;
    end else if (sync) begin
      case (state)
        S_HDR2: begin
          chain_mask <= chain_ena;
          to_mask    <= '0;
          ntok       <= ~(h_tok & (chain_ena != '0));
          ch         <= first_pick[CW-1:0];
        end
        S_TIN: timer <= token_timeout;
        S_WAIT: begin
          if (timer != 16'd0) timer <= timer - 16'd1;
          if (tmo_hit) to_mask[ch] <= 1'b1;
        end
        S_NEXT: begin
          if (nxt_pick[CW]) ch <= nxt_pick[CW-1:0];
          trl_cnt <= 16'(TRL_DELAY);
        end
        S_TRLW: if (trl_cnt != 16'd0) trl_cnt <= trl_cnt - 16'd1;
        default: ;
      endcase
    end
  end

  // Output decode: token strobes, deserializer enables and DAQ words
  always_comb begin
    tin       = '0;
    deser_ena = '0;
    daq_data  = '0;
    word_vld  = 1'b0;
    case (state)
      S_TIN: begin
        tin[ch]       = 1'b1;
        deser_ena[ch] = 1'b1;
      end
      S_WAIT: deser_ena[ch] = 1'b1;
      S_HDR1: begin
        word_vld = 1'b1;
        daq_data = {8'hA0, h_ev};
      end
      S_HDR2: begin
        word_vld = 1'b1;
        daq_data = {8'h80, 4'h0, h_pos};
      end
      S_TRL1: begin
        word_vld = 1'b1;
        daq_data = {8'hE0, ntok, h_flg[F_REST], h_flg[F_RESR], 1'b0,
                    h_flg[F_SYNC], 1'b0, h_flg[F_CAL], h_flg[F_STKF]};
      end
      S_TRL2: begin
        // Auto-reset is never generated here, so its bit stays 0
        word_vld = 1'b1;
        daq_data = {8'hC0, 1'b0, (to_mask != '0), 2'b00, queue_size[3:0]};
      end
      S_TRL3: begin
        word_vld = 1'b1;
        daq_data = {8'hD0, to_mask8};
      end
      default: ;
    endcase
  end

  assign daq_write = word_vld & sync;

endmodule

// File: tb/tb_soft_tbm_mc.sv
// Directed bench for soft_tbm_mc (NCH=4, QDEPTH=4, RO_DELAY=10, TRL_DELAY=4).
`timescale 1ns/1ps
module tb_soft_tbm_mc;

  localparam logic [4:0] E_SYN = 5'b00001;
  localparam logic [4:0] E_TRG = 5'b00010;
  localparam logic [4:0] E_RST = 5'b01000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sync;
  logic [4:0]  trg_in;
  logic [3:0]  trg_pos;
  logic [3:0]  chain_ena;
  logic [15:0] token_timeout;
  logic [3:0]  tin;
  logic [3:0]  tout = '0;
  logic [3:0]  deser_ena;
  logic        cmd_trg, cmd_rsr, cmd_rst, cmd_cal;
  logic        daq_write;
  logic [15:0] daq_data;
  logic [4:0]  queue_size;

  int checks = 0;
  int errors = 0;

  logic [15:0] words[$];
  logic [3:0]  tin_log[$];
  int          tin_cyc[$];
  int          cyc   = 0;
  int          n_rsr = 0;
  int          n_trg = 0;
  int          cd[4] = '{0, 0, 0, 0};
  logic [3:0]  dead;

  soft_tbm_mc #(.NCH(4), .QDEPTH(4), .RO_DELAY(10), .TRL_DELAY(4)) dut (
    .clk(clk), .reset_n(reset_n), .sync(sync), .trg_in(trg_in), .trg_pos(trg_pos),
    .chain_ena(chain_ena), .token_timeout(token_timeout), .tin(tin), .tout(tout),
`ifdef SOFT_TBM_MC_TOUT_DELAY_EN
    .tout_delay_ena(1'b0),
`endif
    .deser_ena(deser_ena), .cmd_trg(cmd_trg), .cmd_rsr(cmd_rsr), .cmd_rst(cmd_rst),
    .cmd_cal(cmd_cal), .daq_write(daq_write), .daq_data(daq_data), .queue_size(queue_size)
  );

  always #5 clk = ~clk;

  // Recorder plus token responder: live chains answer 3 ticks after tin
  always @(negedge clk) begin
    cyc++;
    if (daq_write) words.push_back(daq_data);
    if (tin != 4'h0) begin
      tin_log.push_back(tin);
      tin_cyc.push_back(cyc);
    end
    if (cmd_rsr) n_rsr++;
    if (cmd_trg) n_trg++;
    for (int i = 0; i < 4; i++) begin
      tout[i] = 1'b0;
      if (cd[i] != 0) begin
        cd[i]--;
        if (cd[i] == 0) tout[i] = 1'b1;
      end
      if (tin[i] && !dead[i]) cd[i] = 3;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wd(input int i);
    if (i < words.size()) return {16'h0, words[i]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] tl(input int i);
    if (i < tin_log.size()) return {28'h0, tin_log[i]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [4:0] ev);
    trg_in = ev;
    @(posedge clk);
    #1;
    trg_in = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_drain(input string tag, input int limit);
    int n;
    n = 0;
    while (queue_size != 5'd0 && n < limit) begin
      tick(1);
      n++;
    end
    chk(tag, {27'h0, queue_size}, 32'h0);
    tick(3);
  endtask

  initial begin
    int w0, t0, r0, g0;
    logic [31:0] hdr;
    reset_n = 1'b0; sync = 1'b1; trg_in = '0; trg_pos = 4'd5;
    chain_ena = 4'hF; token_timeout = 16'd100; dead = 4'h0;
    tick(2);
    chk("rst_outs", {tin, deser_ena, cmd_trg, cmd_rsr, cmd_rst, cmd_cal, daq_write}, 32'h0);
    chk("rst_data", {16'h0, daq_data}, 32'h0);
    chk("rst_qsize", {27'h0, queue_size}, 32'h0);
    reset_n = 1'b1;
    tick(1);

    // Single trigger, all four chains answering
    w0 = words.size(); t0 = tin_log.size();
    pulse(E_TRG);
    chk("s1_cmd_trg", {31'h0, cmd_trg}, 32'h1);
    chk("s1_qsize", {27'h0, queue_size}, 32'h1);
    wait_drain("s1_drain", 300);
    chk("s1_nwords", words.size() - w0, 5);
    chk("s1_hdr1", wd(w0), 32'hA000);
    chk("s1_hdr2", wd(w0 + 1), 32'h8005);
    chk("s1_trl1", wd(w0 + 2), 32'hE000);
    chk("s1_trl2", wd(w0 + 3), 32'hC001);
    chk("s1_trl3", wd(w0 + 4), 32'hD000);
    chk("s1_tin_order", {tl(t0 + 3)[3:0], tl(t0 + 2)[3:0], tl(t0 + 1)[3:0], tl(t0)[3:0]}, 32'h8421);

    // Chain 2 never answers and times out; others still read out
    do_reset();
    token_timeout = 16'd20; dead = 4'b0100;
    w0 = words.size(); t0 = tin_log.size(); r0 = n_rsr;
    pulse(E_TRG);
    wait_drain("s2_drain", 300);
    chk("s2_tin_order", {tl(t0 + 3)[3:0], tl(t0 + 2)[3:0], tl(t0 + 1)[3:0], tl(t0)[3:0]}, 32'h8421);
    chk("s2_to_gap", (tin_cyc.size() > t0 + 3) ? tin_cyc[t0 + 3] - tin_cyc[t0 + 2] : -1, 22);
    chk("s2_rsr_cnt", n_rsr - r0, 1);
    chk("s2_trl1", wd(w0 + 2), 32'hE000);
    chk("s2_trl2", wd(w0 + 3), 32'hC041);
    chk("s2_trl3", wd(w0 + 4), 32'hD004);

    // rst during a token wait aborts without trailer
    do_reset();
    token_timeout = 16'd1000; dead = 4'hF;
    w0 = words.size();
    pulse(E_TRG);
    begin
      int n;
      n = 0;
      while (!(deser_ena != 4'h0 && tin == 4'h0) && n < 100) begin
        tick(1);
        n++;
      end
      chk("s5_in_wait", {28'h0, deser_ena}, 32'h1);
    end
    tick(2);
    pulse(E_RST);
    chk("s5_cmds", {30'h0, cmd_rst, cmd_rsr}, 32'h3);
    chk("s5_qsize", {27'h0, queue_size}, 32'h0);
    tick(1);
    chk("s5_idle", {28'h0, deser_ena}, 32'h0);
    tick(20);
    chk("s5_nwords", words.size() - w0, 2);
    dead = 4'h0;

    // Queue overflow with QDEPTH=4, then stkf on the next queued trigger
    do_reset();
    chain_ena = 4'h0; trg_pos = 4'd0;
    w0 = words.size(); g0 = n_trg;
    trg_in = E_TRG;
    tick(5);
    trg_in = '0;
    chk("s3_pushes", n_trg - g0, 4);
    chk("s3_qfull", {27'h0, queue_size}, 32'h4);
    wait_drain("s3_drain", 300);
    chk("s3_nwords", words.size() - w0, 20);
    chk("s3_trl1_first", wd(w0 + 2), 32'hE080);
    chk("s3_trl2_first", wd(w0 + 3), 32'hC004);
    chk("s3_hdr1_last", wd(w0 + 15), 32'hA003);
    chk("s3_trl2_last", wd(w0 + 18), 32'hC001);
    w0 = words.size();
    pulse(E_TRG);
    wait_drain("s3b_drain", 100);
    chk("s3b_hdr1", wd(w0), 32'hA004);
    chk("s3b_trl1_stkf", wd(w0 + 2), 32'hE081);

    // sync low holds all state; then chain_ena=0 gives no token pass
    do_reset();
    chain_ena = 4'h0; trg_pos = 4'd5;
    sync = 1'b0;
    trg_in = E_TRG;
    tick(2);
    trg_in = '0;
    chk("s6_nosync", {26'h0, queue_size, cmd_trg}, 32'h0);
    sync = 1'b1;
    w0 = words.size(); t0 = tin_log.size();
    pulse(E_TRG);
    wait_drain("s6_drain", 100);
    chk("s6_no_tin", tin_log.size() - t0, 0);
    chk("s6_hdr2", wd(w0 + 1), 32'h8005);
    chk("s6_trl1_ntok", wd(w0 + 2), 32'hE080);

    // Event counter wrap, then syn together with trg
    do_reset();
    chain_ena = 4'h0;
    hdr = '0;
    for (int i = 0; i < 256; i++) begin
      w0 = words.size();
      pulse(E_TRG);
      wait_drain("s4_drain", 60);
      hdr = wd(w0);
    end
    chk("s4_hdr_ff", hdr, 32'hA0FF);
    w0 = words.size();
    pulse(E_TRG);
    wait_drain("s4_drain_wrap", 60);
    chk("s4_hdr_wrap", wd(w0), 32'hA000);
    w0 = words.size();
    pulse(E_TRG | E_SYN);
    wait_drain("s4_drain_syn", 60);
    chk("s4_hdr_syn", wd(w0), 32'hA001);
    w0 = words.size();
    pulse(E_TRG);
    wait_drain("s4_drain_after", 60);
    chk("s4_hdr_after", wd(w0), 32'hA000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
